// File: rtl/multi_evt_counter.sv
// Multi-channel event counter, per-channel wrap/saturate terminal, coherent snapshot readback; EVT_EDGE_DETECT_EN selects edge counting.
// 1-cycle latency on counts and reads; no backpressure, every qualified event is taken.
module multi_evt_counter #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_COUNT = 1_000_000_000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       clr_in,
  input  logic                    sat_mode_in,
  input  logic                    cfg_we_in,
  input  logic [CH_W-1:0]         cfg_ch_in,
  input  logic [WIDTH-1:0]        cfg_term_in,
  input  logic                    snap_in,
  input  logic [CH_W-1:0]         rd_ch_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       wrap_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic [WIDTH-1:0]        rd_data_out
);

  localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0]  cnt    [NUM_CH];
  logic [WIDTH-1:0]  term   [NUM_CH];
  logic [WIDTH-1:0]  shadow [NUM_CH];
  logic [WIDTH-1:0]  rd_sel;
  logic [NUM_CH-1:0] qual;

`ifdef EVT_EDGE_DETECT_EN
  logic [NUM_CH-1:0] evt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) evt_q <= '0;
    else           evt_q <= evt_in;
  end

  assign qual = evt_in & ~evt_q;
`else
  assign qual = evt_in;
`endif

  // Out-of-range cfg/read channels simply match no entry, so they need no extra guard.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        term[i]   <= TERM_RST;
        shadow[i] <= '0;
      end
      wrap_out <= '0;
      sat_out  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap_in) shadow[i] <= cnt[i];
        if (cfg_we_in && (cfg_ch_in == CH_W'(i))) term[i] <= cfg_term_in;
        if (clr_in[i]) begin
          cnt[i]      <= '0;
          wrap_out[i] <= 1'b0;
          sat_out[i]  <= 1'b0;
        end else if (qual[i]) begin
          if (cnt[i] < term[i]) begin
            cnt[i]      <= cnt[i] + ONE;
            wrap_out[i] <= 1'b0;
          end else if (sat_mode_in) begin
            sat_out[i]  <= 1'b1;
            wrap_out[i] <= 1'b0;
          end else begin
            cnt[i]      <= '0;
            wrap_out[i] <= 1'b1;
          end
        end else begin
          wrap_out[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_in == CH_W'(i)) rd_sel = shadow[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rd_data_out <= '0;
    else           rd_data_out <= rd_sel;
  end

  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_out[i*WIDTH +: WIDTH] = cnt[i];
    end
  end

endmodule

// File: tb/tb_multi_evt_counter.sv
// Bench for multi_evt_counter: directed stimulus feeds a scoreboard queue, a negedge monitor pops and compares.
module tb_multi_evt_counter;

`ifdef EVT_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [3:0]  evt_in, clr_in;
  logic        sat_mode_in, cfg_we_in, snap_in;
  logic [1:0]  cfg_ch_in, rd_ch_in;
  logic [7:0]  cfg_term_in;
  logic [31:0] count_out;
  logic [3:0]  wrap_out, sat_out;
  logic [7:0]  rd_data_out;
  logic [23:0] count3;
  logic [2:0]  wrap3, sat3;
  logic [7:0]  rd3;

  multi_evt_counter #(.NUM_CH(4), .WIDTH(8), .MAX_COUNT(10)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .evt_in(evt_in), .clr_in(clr_in),
    .sat_mode_in(sat_mode_in), .cfg_we_in(cfg_we_in), .cfg_ch_in(cfg_ch_in),
    .cfg_term_in(cfg_term_in), .snap_in(snap_in), .rd_ch_in(rd_ch_in),
    .count_out(count_out), .wrap_out(wrap_out), .sat_out(sat_out),
    .rd_data_out(rd_data_out)
  );

  // Three-channel copy: channel index 3 is out of range here.
  multi_evt_counter #(.NUM_CH(3), .WIDTH(8), .MAX_COUNT(10)) u_dut3 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .evt_in(evt_in[2:0]), .clr_in(clr_in[2:0]),
    .sat_mode_in(sat_mode_in), .cfg_we_in(cfg_we_in), .cfg_ch_in(cfg_ch_in),
    .cfg_term_in(cfg_term_in), .snap_in(snap_in), .rd_ch_in(rd_ch_in),
    .count_out(count3), .wrap_out(wrap3), .sat_out(sat3),
    .rd_data_out(rd3)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int    cyc;
    int    kind;
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic exp_at(input int t, input int kind, input int ch, input int val, input string name);
    exp_t e;
    e.cyc = t; e.kind = kind; e.ch = ch; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  // kinds: 0 count, 1 wrap, 2 sat, 3 rd_data, 4 count (3-ch copy), 5 rd_data (3-ch copy)
  task automatic exp_next(input int kind, input int ch, input int val, input string name);
    exp_at(cyc + 1, kind, ch, val, name);
  endtask

  task automatic exp_now(input int kind, input int ch, input int val, input string name);
    exp_at(cyc, kind, ch, val, name);
  endtask

  function automatic int actual(input int kind, input int ch);
    case (kind)
      0:       return int'(count_out[ch*8 +: 8]);
      1:       return int'(wrap_out[ch]);
      2:       return int'(sat_out[ch]);
      3:       return int'(rd_data_out);
      4:       return int'(count3[ch*8 +: 8]);
      5:       return int'(rd3);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk_in) begin : monitor
    exp_t e;
    int   a;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      a = actual(e.kind, e.ch);
      total++;
      if (a != e.val) begin
        bad++;
        $display("FAIL %s ch%0d: got %0d want %0d (cycle %0d)", e.name, e.ch, a, e.val, cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    evt_in = '0; clr_in = '0; cfg_we_in = 1'b0; snap_in = 1'b0;
  endtask

  // One-cycle event followed by a quiet cycle, so level and edge builds count alike.
  task automatic ev(input logic [3:0] mask);
    evt_in = mask;
    tick;
    evt_in = '0;
    tick;
  endtask

  initial begin
    rst_n_in = 1'b0; sat_mode_in = 1'b0; rd_ch_in = '0; cfg_ch_in = '0; cfg_term_in = '0;
    idle;
    tick; tick;
    for (int c = 0; c < 4; c++) begin
      exp_next(0, c, 0, "rst_cnt");
      exp_next(1, c, 0, "rst_wrap");
      exp_next(2, c, 0, "rst_sat");
    end
    exp_next(3, 0, 0, "rst_rd");
    tick;
    rst_n_in = 1'b1;

    // wrap mode, term 9 after reset
    for (int k = 1; k <= 12; k++) begin
      exp_next(0, 0, k % 10, "t1_cnt");
      exp_next(1, 0, (k == 10) ? 1 : 0, "t1_wrap");
      ev(4'b0001);
    end
    exp_next(0, 0, 2, "t1_hold");
    exp_next(1, 0, 0, "t1_wrap_low");
    tick;

    // saturate mode
    sat_mode_in = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      exp_next(0, 1, (k < 9) ? k : 9, "t2_cnt");
      exp_next(2, 1, (k >= 10) ? 1 : 0, "t2_sat");
      exp_next(1, 1, 0, "t2_wrap");
      ev(4'b0010);
    end
    sat_mode_in = 1'b0;
    exp_next(2, 1, 1, "t2_sticky");
    exp_next(0, 1, 9, "t2_hold");
    tick;
    exp_next(0, 1, 0, "t2_mode_wrap_cnt");
    exp_next(1, 1, 1, "t2_mode_wrap");
    exp_next(2, 1, 1, "t2_sticky2");
    ev(4'b0010);

    // term 3 on ch2
    cfg_we_in = 1'b1; cfg_ch_in = 2'd2; cfg_term_in = 8'd3;
    exp_next(0, 2, 0, "t3_cfg_cnt");
    tick;
    cfg_we_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_next(0, 2, k % 4, "t3_cnt");
      exp_next(1, 2, (k == 4) ? 1 : 0, "t3_wrap");
      ev(4'b0100);
    end

    // term 0 on ch3; the 3-channel copy must ignore that write
    cfg_we_in = 1'b1; cfg_ch_in = 2'd3; cfg_term_in = 8'd0;
    tick;
    cfg_we_in = 1'b0;
    exp_next(4, 0, 3, "oor_cfg_cnt");
    exp_next(4, 1, 1, "oor_cfg_cnt");
    exp_next(4, 2, 2, "oor_cfg_cnt");
    exp_next(0, 2, 2, "t3_cnt_after");
    ev(4'b0111);
    for (int k = 1; k <= 2; k++) begin
      exp_next(0, 3, 0, "term0_cnt");
      exp_next(1, 3, 1, "term0_wrap");
      ev(4'b1000);
    end
    exp_next(1, 3, 0, "term0_wrap_low");
    tick;
    cfg_we_in = 1'b1; cfg_ch_in = 2'd3; cfg_term_in = 8'd9;
    tick;
    cfg_we_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_next(0, 3, k, "ch3_cnt");
      ev(4'b1000);
    end

    // snapshot, event and clear in one cycle
    snap_in = 1'b1; clr_in = 4'b0001; evt_in = 4'b1000;
    exp_next(0, 3, 4, "t4_live3");
    exp_next(0, 0, 0, "t4_clr0");
    exp_next(2, 1, 1, "t4_sticky");
    tick;
    idle;
    rd_ch_in = 2'd3;
    exp_next(3, 0, 3, "t4_rd3");
    exp_next(5, 0, 0, "oor_rd");
    tick;
    rd_ch_in = 2'd0;
    exp_next(3, 0, 3, "t4_rd0");
    tick;
    rd_ch_in = 2'd1;
    exp_next(3, 0, 1, "t4_rd1");
    tick;
    rd_ch_in = 2'd2;
    exp_next(3, 0, 2, "t4_rd2");
    exp_next(5, 0, 2, "rd2_3ch");
    tick;

    // clear beats a coincident event and drops sticky sat
    clr_in = 4'b0010; evt_in = 4'b0010;
    exp_next(0, 1, 0, "clr_cnt");
    exp_next(2, 1, 0, "clr_sat");
    tick;
    idle;
    tick;

    // asynchronous reset between edges
    for (int k = 1; k <= 2; k++) begin
      exp_next(0, 0, k, "t5_pre");
      ev(4'b0001);
    end
    #2;
    rst_n_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_now(0, c, 0, "t5_async_cnt");
      exp_now(1, c, 0, "t5_async_wrap");
    end
    exp_now(3, 0, 0, "t5_async_rd");
    tick;
    rst_n_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_next(0, 2, k, "t5_term_restored");
      ev(4'b0100);
    end

    // held input: edge build counts once, level build every cycle
    evt_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      exp_next(0, 0, EDGE ? 1 : k, "t6_held");
      tick;
    end
    idle;
    tick;

    for (int w = 0; w < 10 && sbq.size() > 0; w++) tick;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
